// File: rtl/tt_um_christina_mankowski_nand_tester.sv
// tt_um_christina_mankowski_nand_tester: walks A/B through all four NAND input
// vectors, compares the observed gate output with ~(A&B) and reports a per-vector fail mask.
module tt_um_christina_mankowski_nand_tester #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
    localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);
    state_t     state_q;
    logic [3:0] s1_q, s2_q, cnt_q, mask_q;
    logic [1:0] rdy_q, idx_q, idx_n;
    logic [2:0] err_q;
    logic       start_prev_q, armed_q, a_q, b_q;
    logic       start_ev, abort, exp_y, obs, mism, busy, done, unused;
    // Arming waits for the synchronizer to refill after reset and see start low,
    // so a start held high through reset never looks like a fresh edge.
    assign start_ev = armed_q & s2_q[0] & ~start_prev_q;
    assign abort    = s2_q[1];
    assign exp_y    = ~(a_q & b_q);
    assign obs      = (s2_q[3] ? uio_in[2] : exp_y) ^ s2_q[2];
    assign mism     = obs ^ exp_y;
    assign idx_n    = idx_q + 2'd1;
    assign busy     = (state_q == APPLY) || (state_q == SAMPLE);
    assign done     = state_q == DONE;
    assign uo_out   = {1'b0, err_q, done && err_q == 3'd0, done, busy, obs};
    assign uio_out  = {mask_q, 2'b00, b_q, a_q};
    assign uio_oe   = 8'b1111_0011;
    assign unused   = &{1'b0, ena, ui_in[7:4], uio_in[7:3], uio_in[1:0]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            s1_q         <= '0;
            s2_q         <= '0;
            start_prev_q <= 1'b0;
            rdy_q        <= '0;
            armed_q      <= 1'b0;
            idx_q        <= '0;
            cnt_q        <= '0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            mask_q       <= '0;
            err_q        <= '0;
        end else begin
            s1_q         <= ui_in[3:0];
            s2_q         <= s1_q;
            start_prev_q <= s2_q[0];
            rdy_q        <= {rdy_q[0], 1'b1};
            if (rdy_q[1] && !s2_q[0]) armed_q <= 1'b1;
            if (abort) begin
                state_q <= IDLE;
                idx_q   <= '0;
                cnt_q   <= '0;
                a_q     <= 1'b0;
                b_q     <= 1'b0;
                mask_q  <= '0;
                err_q   <= '0;
            end else begin
                case (state_q)
                    IDLE, DONE: if (start_ev) begin
                        state_q <= APPLY;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                        mask_q  <= '0;
                        err_q   <= '0;
                    end
                    APPLY: begin
                        state_q <= (cnt_q == LAST) ? SAMPLE : APPLY;
                        cnt_q   <= (cnt_q == LAST) ? 4'd0 : cnt_q + 4'd1;
                    end
                    SAMPLE: begin
                        mask_q[idx_q] <= mism;
                        err_q         <= err_q + {2'b00, mism};
                        if (idx_q == 2'd3) state_q <= DONE;
                        else begin
                            state_q <= APPLY;
                            idx_q   <= idx_n;
                            a_q     <= idx_n[0];
                            b_q     <= idx_n[1];
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tt_um_christina_mankowski_nand_tester.sv
// tb_tt_um_christina_mankowski_nand_tester: directed self-checking bench for the NAND tester.
module tb_tt_um_christina_mankowski_nand_tester;
    logic       clk = 1'b0;
    logic       rst_n, ena, stuck;
    logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;
    int         n_cmp = 0;
    int         n_err = 0;

    tt_um_christina_mankowski_nand_tester dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;
    // External gate model: a good NAND, or an output stuck at 1
    assign uio_in = {5'b0, stuck | ~(uio_out[0] & uio_out[1]), 2'b00};

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start seen at the next edge k; APPLY holds after edge k+2
    task automatic start_pulse();
        ui_in[0] = 1'b1;
        tick(3);
        ui_in[0] = 1'b0;
    endtask

    task automatic run_vectors(input bit restart);
        for (int v = 0; v < 4; v++) begin
            chk($sformatf("ab_v%0d", v), {30'b0, uio_out[1:0]}, v);
            chk($sformatf("busy_apply_v%0d", v), {31'b0, uo_out[1]}, 1);
            if (restart && v == 1) ui_in[0] = 1'b1;
            if (restart && v == 2) ui_in[0] = 1'b0;
            tick(4);
            chk($sformatf("busy_sample_v%0d", v), {31'b0, uo_out[2:1]}, 1);
            tick(1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ena   = 1'b1;
        ui_in = 8'h00;
        stuck = 1'b0;
        tick(2);
        chk("reset_uo", {24'b0, uo_out}, 8'h01);
        chk("reset_uio", {24'b0, uio_out}, 8'h00);
        chk("uio_oe", {24'b0, uio_oe}, 8'hF3);
        rst_n = 1'b1;
        tick(5);
        chk("idle_after_reset", {24'b0, uo_out}, 8'h01);

        start_pulse();
        run_vectors(1'b1);
        chk("good_uo", {24'b0, uo_out}, 8'h0C);
        chk("good_uio", {24'b0, uio_out}, 8'h03);
        tick(3);
        chk("done_hold", {24'b0, uo_out}, 8'h0C);

        ui_in[2] = 1'b1;
        tick(3);
        start_pulse();
        run_vectors(1'b0);
        chk("fault_uo", {24'b0, uo_out}, 8'h45);
        chk("fault_uio", {24'b0, uio_out}, 8'hF3);
        ui_in[2] = 1'b0;

        ui_in[3] = 1'b1;
        tick(3);
        start_pulse();
        run_vectors(1'b0);
        chk("ext_good_uo", {24'b0, uo_out}, 8'h0C);
        chk("ext_good_uio", {24'b0, uio_out}, 8'h03);
        stuck = 1'b1;
        start_pulse();
        run_vectors(1'b0);
        chk("ext_stuck_uo", {24'b0, uo_out}, 8'h15);
        chk("ext_stuck_uio", {24'b0, uio_out}, 8'h83);
        stuck = 1'b0;
        ui_in[3] = 1'b0;

        ui_in[2] = 1'b1;
        tick(3);
        start_pulse();
        tick(10);
        chk("abort_pre_uio", {24'b0, uio_out}, 8'h32);
        ui_in[1] = 1'b1;
        tick(3);
        chk("abort_uo", {24'b0, uo_out}, 8'h00);
        chk("abort_uio", {24'b0, uio_out}, 8'h00);
        ui_in[0] = 1'b1;
        tick(5);
        chk("start_during_abort", {31'b0, uo_out[1]}, 0);
        ui_in[1] = 1'b0;
        tick(5);
        chk("start_held_after_abort", {31'b0, uo_out[1]}, 0);
        ui_in = 8'h00;
        tick(3);

        ui_in[0] = 1'b1;
        tick(3);
        chk("run_before_reset", {31'b0, uo_out[1]}, 1);
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_uo", {24'b0, uo_out[7:1], 1'b0}, 8'h00);
        chk("midrun_reset_uio", {24'b0, uio_out}, 8'h00);
        tick(2);
        rst_n = 1'b1;
        tick(10);
        chk("no_run_held_start", {24'b0, uo_out}, 8'h01);
        ui_in[0] = 1'b0;
        tick(4);
        start_pulse();
        run_vectors(1'b0);
        chk("post_reset_run_uo", {24'b0, uo_out}, 8'h0C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tt_um_christina_mankowski_nand_tester.md
TT_UM_CHRISTINA_MANKOWSKI_NAND_TESTER -- requirements
Module: tt_um_christina_mankowski_nand_tester

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 4, meaning cycles each input vector is held before its result is sampled (legal range 1..15).
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 The block SHALL have port ena  input  1  power-good; ignored.
REQ-005 The block SHALL have port ui_in  input  8  [0]=start, [1]=abort, [2]=fault_inject (invert observed result), [3]=ext_sel (1=test external gate on uio_in[2], 0=internal NAND), [7:4] unused.
REQ-006 The block SHALL have port uo_out  output  8  [0]=observed Y, [1]=busy, [2]=done, [3]=pass, [6:4]=err_count, [7]=0.
REQ-007 The block SHALL have port uio_in  input  8  [2]=external gate Y; other bits unused.
REQ-008 The block SHALL have port uio_out  output  8  [0]=A drive, [1]=B drive, [3:2]=0, [7:4]=fail_mask (bit i = vector i mismatched).
REQ-009 The block SHALL have port uio_oe  output  8  constant 8'b1111_0011.

Function
REQ-010 ui_in[3:0] SHALL pass through a 2-flop synchronizer; all control decisions use synchronized values only.
REQ-011 A start event SHALL be the rising edge of synchronized start (sync high, previous-cycle sync low); with ui_in[0] first sampled high at edge k, the FSM SHALL be in APPLY after edge k+2.
REQ-012 FSM states SHALL be IDLE, APPLY, SAMPLE, DONE.
REQ-013 IDLE/DONE + start event -> APPLY with idx=0, settle counter=0, fail_mask=0, err_count=0, done=0.
REQ-014 APPLY SHALL drive A=idx[0], B=idx[1] and remain for exactly SETTLE_CYCLES cycles, then -> SAMPLE.
REQ-015 SAMPLE (one cycle) SHALL capture observed = (ext_sel ? uio_in[2] : ~(A&B)) XOR fault_inject, compare with expected ~(A&B), set fail_mask[idx] and increment err_count on mismatch.
REQ-016 SAMPLE with idx<3 -> APPLY with idx+1; SAMPLE with idx==3 -> DONE.
REQ-017 Full run SHALL take 4*(SETTLE_CYCLES+1) cycles from APPLY entry to DONE entry (20 cycles at default).
REQ-018 busy SHALL be 1 in APPLY and SAMPLE, else 0; done SHALL be 1 only in DONE; pass SHALL be done AND err_count==0.
REQ-019 err_count SHALL be 3 bits, range 0..4, equal to popcount(fail_mask); no wrap.
REQ-020 DONE SHALL hold A, B, fail_mask, err_count until the next start event; A, B remain at last vector (1,1).
REQ-021 Start events while busy SHALL be ignored.
REQ-022 Synchronized abort high SHALL force IDLE next cycle from any state, clear fail_mask, err_count, idx, A, B; abort has priority over a simultaneous start event; start events are ignored while abort is high.
REQ-023 uo_out[0] SHALL show the observed value combinationally from current A, B, ext_sel, fault_inject in all states.
REQ-024 Unused inputs SHALL not affect any output.

Reset
REQ-025 rst_n low SHALL immediately (asynchronously) force IDLE, idx=0, A=B=0, fail_mask=0, err_count=0, busy=done=pass=0, and clear synchronizer and edge-detect flops.
REQ-026 Reset asserted mid-run SHALL abandon the run; after release, no run starts until a new start event (a start held high through reset SHALL NOT trigger).

Verification
REQ-027 Internal mode, no fault: pulse start -> busy for 20 cycles, A/B sequence 00,10,01,11, then done=1, pass=1, err_count=0, fail_mask=0000.
REQ-028 fault_inject=1 whole run -> done=1, pass=0, err_count=4, fail_mask=1111.
REQ-029 ext_sel=1, external model drives uio_in[2]=0 only when A=B=1 -> pass=1; model stuck at 1 -> err_count=1, fail_mask=1000.
REQ-030 Abort asserted at vector 2 -> IDLE within 3 cycles of ui_in[1] rising, busy=0, fail_mask=0, A=B=0; second start pulse during busy does not restart (run still 20 cycles).
REQ-031 rst_n pulsed low mid-APPLY with start held high -> all outputs zero during reset; no run after release until start toggles low then high.
